// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, command ops,
// header TMS patterns and sequencer FSM states.
package tap_pkg;

   typedef enum logic [3:0] {
      TLR      = 4'h0,
      RTI      = 4'h1,
      SEL_DR   = 4'h2,
      CAP_DR   = 4'h3,
      SHIFT_DR = 4'h4,
      EXIT1_DR = 4'h5,
      PAUSE_DR = 4'h6,
      EXIT2_DR = 4'h7,
      UPD_DR   = 4'h8,
      SEL_IR   = 4'h9,
      CAP_IR   = 4'hA,
      SHIFT_IR = 4'hB,
      EXIT1_IR = 4'hC,
      PAUSE_IR = 4'hD,
      EXIT2_IR = 4'hE,
      UPD_IR   = 4'hF
   } tap_state_e;

   typedef enum logic [1:0] {
      OP_DR  = 2'b00,
      OP_IR  = 2'b01,
      OP_RST = 2'b10,
      OP_BAD = 2'b11
   } cmd_op_e;

   // bit i is the TMS value on header edge i+1
   localparam logic [3:0] HDR_DR = 4'b0001;
   localparam logic [3:0] HDR_IR = 4'b0011;
   localparam int HDR_DR_LEN = 3;
   localparam int HDR_IR_LEN = 4;
   localparam int RST_ONES   = 5;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_RST_SEQ,
      S_HDR,
      S_SHIFT,
      S_EXIT,
      S_UPD,
      S_RESP
   } seq_state_e;

endpackage

// File: rtl/tap_state_mirror.sv
// IEEE 1149.1 TAP controller state machine.
// Tracks the TAP from the same TMS and clock.
module tap_state_mirror
   import tap_pkg::*;
(
   input  logic       clk,
   input  logic       TRST,
   input  logic       tms,
   output tap_state_e state
);

   tap_state_e nxt;

   // standard TAP transition function
   always_comb begin
      nxt = state;
      unique case (state)
         TLR:      nxt = tms ? TLR      : RTI;
         RTI:      nxt = tms ? SEL_DR   : RTI;
         SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   nxt = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: nxt = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: nxt = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: nxt = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: nxt = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   nxt = tms ? SEL_DR   : RTI;
         SEL_IR:   nxt = tms ? TLR      : CAP_IR;
         CAP_IR:   nxt = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: nxt = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: nxt = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: nxt = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: nxt = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   nxt = tms ? SEL_DR   : RTI;
      endcase
   end

   // state register, TRST forces Test_Logic_Reset
   always_ff @(posedge clk) begin
      if (TRST) state <= TLR;
      else      state <= nxt;
   end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: walks the TAP through
// DR/IR scans or a reset and returns captured TDO.
module jtag_scan_sequencer
   import tap_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6
) (
   input  logic               clk,
   input  logic               TRST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   input  logic               tdo,
   output logic               tms,
   output logic               tdi,
   output logic               rsp_valid,
   output logic               rsp_err,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic [3:0]         tap_state,
   output logic               busy
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
   localparam logic [LEN_W-1:0] MAXL     = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(RST_ONES);
   localparam logic [LEN_W-1:0] DR_LAST  = LEN_W'(HDR_DR_LEN - 1);
   localparam logic [LEN_W-1:0] IR_LAST  = LEN_W'(HDR_IR_LEN - 1);

   seq_state_e         state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   cmd_op_e            op_q;
   logic [LEN_W-1:0]   len_q;
   logic [MAX_LEN-1:0] data_q, cap_q;
   logic               err_q, pend_q;
   logic               acc, recover, bad_cmd;
   logic               tms_m, hdr_last, shift_last;
   logic [IDX_W-1:0]   idx;
   tap_state_e         mir;

   tap_state_mirror u_mirror (
      .clk   (clk),
      .TRST  (TRST),
      .tms   (tms),
      .state (mir)
   );

   assign idx        = cnt_q[IDX_W-1:0];
   assign hdr_last   = cnt_q == ((op_q == OP_IR) ? IR_LAST : DR_LAST);
   assign shift_last = cnt_q == (len_q - ONE);
   assign bad_cmd    = (cmd_op == OP_BAD) ||
                       ((cmd_op != OP_RST) &&
                        ((cmd_len == '0) || (cmd_len > MAXL)));

   assign cmd_ready = ((state_q == S_IDLE) || (state_q == S_RESP))
                      && (mir == RTI);
   assign rsp_valid = state_q == S_RESP;
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_data  = cap_q;
   assign tap_state = mir;
   assign busy      = (state_q == S_RST_SEQ) || (state_q == S_HDR) ||
                      (state_q == S_SHIFT) || (state_q == S_EXIT) ||
                      (state_q == S_UPD);
   assign tdi       = (state_q == S_SHIFT) ? data_q[idx] : 1'b0;
   assign tms       = TRST | tms_m;

   // next state, bit counter and command accept
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + ONE;
      acc     = 1'b0;
      recover = 1'b0;
      unique case (state_q)
         S_INIT: state_d = S_IDLE;
         S_IDLE, S_RESP: begin
            cnt_d = '0;
            if (mir != RTI) begin
               state_d = S_RST_SEQ;
               recover = 1'b1;
            end else if (cmd_valid) begin
               acc = 1'b1;
               if (bad_cmd)
                  state_d = S_RESP;
               else if (cmd_op == OP_RST)
                  state_d = S_RST_SEQ;
               else
                  state_d = S_HDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RST_SEQ:
            if (cnt_q == RST_LAST)
               state_d = pend_q ? S_RESP : S_IDLE;
         S_HDR:
            if (hdr_last) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end
         S_SHIFT: if (shift_last) state_d = S_EXIT;
         S_EXIT:  state_d = S_UPD;
         S_UPD:   state_d = S_RESP;
         default: state_d = S_INIT;
      endcase
   end

   // Moore TMS decode from state and counter
   always_comb begin
      tms_m = 1'b0;
      unique case (state_q)
         S_RST_SEQ: tms_m = cnt_q != RST_LAST;
         S_HDR:     tms_m = (op_q == OP_IR) ? HDR_IR[cnt_q[1:0]]
                                            : HDR_DR[cnt_q[1:0]];
         S_SHIFT:   tms_m = shift_last;
         S_EXIT:    tms_m = 1'b1;
         default:   tms_m = 1'b0;
      endcase
   end

   // sequencer registers, command latch and TDO capture
   always_ff @(posedge clk) begin
      if (TRST) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         op_q    <= OP_DR;
         len_q   <= '0;
         data_q  <= '0;
         cap_q   <= '0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (recover) pend_q <= 1'b0;
         if (acc) begin
            op_q   <= cmd_op_e'(cmd_op);
            len_q  <= cmd_len;
            data_q <= cmd_data;
            cap_q  <= '0;
            err_q  <= bad_cmd;
            pend_q <= 1'b1;
         end
         if (state_q == S_SHIFT) cap_q[idx] <= tdo;
      end
   end

endmodule
